control_edicion: RTL and testbench

Edit-mode controller that sequences the button demultiplexer of the RTC console. It turns the raw mode-select buttons (P_FECHA, P_HORA, P_CRONO) and edit buttons (SUMAR, RESTAR, DERECHA, IZQUIERDA) into a one-hot target select, a field cursor and single-cycle increment/decrement strobes. Its outputs drive the demultiplexer select and the write enables of the date, time and stopwatch register banks. It sits between the button front end and the register banks.

---
 rtl/control_edicion.sv | 119 +++++++++++
 tb/tb_control_edicion.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/control_edicion.sv
// Edit-mode controller for the RTC console: conditions raw buttons into edges and
// sequences target select, field cursor and inc/dec strobes. Optional macro: EDIT_TIMEOUT_EN.
module control_edicion #(
  parameter int T_INACT  = 2_000_000,
  parameter int N_CAMPOS = 3
) (
  input  logic       clk,
  input  logic       resetM,
  input  logic       P_FECHA,
  input  logic       P_HORA,
  input  logic       P_CRONO,
  input  logic       SUMAR,
  input  logic       RESTAR,
  input  logic       DERECHA,
  input  logic       IZQUIERDA,
  output logic       sel_fecha,
  output logic       sel_hora,
  output logic       sel_crono,
  output logic [1:0] campo,
  output logic       inc_p,
  output logic       dec_p,
  output logic       editando
);

  localparam int         NB   = 7;
  localparam logic [1:0] CMAX = 2'(N_CAMPOS - 1);

  typedef enum logic [1:0] {REPOSO, ED_FECHA, ED_HORA, ED_CRONO} state_t;

  state_t          state, state_n, tgt;
  logic [NB-1:0]   btn, s1, s2, dly, edg;
  logic [2:0]      arm;
  logic [1:0]      campo_n;
  logic            mode_any, editing, ed_ok, der, izq, sum, res, edit_acc, tmo;

  assign btn = {IZQUIERDA, DERECHA, RESTAR, SUMAR, P_CRONO, P_HORA, P_FECHA};

  // arm masks edges until dly has captured the post-reset level, so a button
  // held through reset needs a release and a fresh press to be seen.
  always_ff @(posedge clk or negedge resetM) begin
    if (!resetM) begin
      s1  <= '0;
      s2  <= '0;
      dly <= '0;
      arm <= '0;
    end else begin
      s1  <= btn;
      s2  <= s1;
      dly <= s2;
      arm <= {arm[1:0], 1'b1};
    end
  end

  assign edg = arm[2] ? (s2 & ~dly) : '0;

  assign mode_any = |edg[2:0];
  assign tgt      = edg[0] ? ED_FECHA : (edg[1] ? ED_HORA : ED_CRONO);
  assign editing  = (state != REPOSO);
  assign ed_ok    = editing & ~mode_any;
  assign sum      = ed_ok & edg[3];
  assign res      = ed_ok & edg[4];
  assign der      = ed_ok & edg[5];
  assign izq      = ed_ok & edg[6];
  assign edit_acc = sum | res | der | izq;

`ifdef EDIT_TIMEOUT_EN
  localparam int            CW  = $clog2(T_INACT);
  localparam logic [CW-1:0] RLD = CW'(T_INACT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge resetM) begin
    if (!resetM)                             cnt <= RLD;
    else if (!editing || mode_any || edit_acc) cnt <= RLD;
    else if (cnt != '0)                      cnt <= cnt - CW'(1);
  end

  assign tmo = editing & (cnt == '0) & ~edit_acc;
`else
  // no inactivity timer in this build
  assign tmo = 1'b0 && (T_INACT > 0);
`endif

  always_comb begin
    state_n = state;
    campo_n = campo;
    if (mode_any) begin
      state_n = (state == tgt) ? REPOSO : tgt;
      campo_n = 2'd0;
    end else if (tmo) begin
      state_n = REPOSO;
      campo_n = 2'd0;
    end else if (der && !izq) begin
      campo_n = (campo == CMAX) ? 2'd0 : campo + 2'd1;
    end else if (izq && !der) begin
      campo_n = (campo == 2'd0) ? CMAX : campo - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetM) begin
    if (!resetM) begin
      state <= REPOSO;
      campo <= 2'd0;
      inc_p <= 1'b0;
      dec_p <= 1'b0;
    end else begin
      state <= state_n;
      campo <= campo_n;
      inc_p <= sum & ~res;
      dec_p <= res & ~sum;
    end
  end

  assign sel_fecha = (state == ED_FECHA);
  assign sel_hora  = (state == ED_HORA);
  assign sel_crono = (state == ED_CRONO);
  assign editando  = editing;

endmodule

// File: tb/tb_control_edicion.sv
// Scoreboard bench for control_edicion: the driver queues each expected output change
// with the cycle it must appear on; a monitor pops and compares on every output change.
module tb_control_edicion;

  localparam logic [6:0] B_F = 7'h01, B_H = 7'h02, B_C = 7'h04, B_S = 7'h08,
                         B_R = 7'h10, B_D = 7'h20, B_I = 7'h40;
  localparam logic [2:0] SF = 3'b100, SH = 3'b010, SC = 3'b001, S0 = 3'b000;

  logic       clk = 1'b0;
  logic       resetM = 1'b0;
  logic [6:0] btn = '0;
  logic       sel_fecha, sel_hora, sel_crono, inc_p, dec_p, editando;
  logic [1:0] campo;

  control_edicion #(.T_INACT(16), .N_CAMPOS(3)) dut (
    .clk(clk), .resetM(resetM),
    .P_FECHA(btn[0]), .P_HORA(btn[1]), .P_CRONO(btn[2]),
    .SUMAR(btn[3]), .RESTAR(btn[4]), .DERECHA(btn[5]), .IZQUIERDA(btn[6]),
    .sel_fecha(sel_fecha), .sel_hora(sel_hora), .sel_crono(sel_crono),
    .campo(campo), .inc_p(inc_p), .dec_p(dec_p), .editando(editando)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] v; int c; string name; } exp_t;
  exp_t q[$];
  int   errors = 0, checks = 0, t0 = 0;

  logic [7:0] outv;
  assign outv = {sel_fecha, sel_hora, sel_crono, campo, inc_p, dec_p, editando};

  function automatic logic [7:0] ov(input logic [2:0] s, input logic [1:0] c,
                                    input logic i, input logic d);
    return {s, c, i, d, |s};
  endfunction

  task automatic push(input string n, input logic [7:0] v, input int c);
    exp_t e;
    e.v = v; e.c = c; e.name = n;
    q.push_back(e);
  endtask

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", n, act, req);
    end
  endtask

  task automatic press(input logic [6:0] m);
    @(negedge clk);
    btn = btn | m;
    t0  = cyc;
  endtask

  task automatic release_after(input logic [6:0] m, input int hold, input int gap);
    repeat (hold) @(negedge clk);
    btn = btn & ~m;
    repeat (gap) @(negedge clk);
  endtask

  // monitor: every output change must match the head of the queue
  logic [7:0] prev = '0;
  exp_t       me;
  always @(negedge clk) begin
    if (outv !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got %b at cyc %0d, required no change from %b",
                 outv, cyc, prev);
      end else begin
        me = q.pop_front();
        if (outv !== me.v || (me.c >= 0 && cyc != me.c)) begin
          errors++;
          $display("FAIL %s: got %b at cyc %0d, required %b at cyc %0d",
                   me.name, outv, cyc, me.v, me.c);
        end
      end
      prev = outv;
    end
  end

  initial begin
    int e;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outv, 8'h00);
    @(negedge clk); resetM = 1'b1;
    repeat (4) @(negedge clk);

    // reset mid-run, then entry
    press(B_F); push("enter_fecha", ov(SF, 0, 0, 0), t0 + 3); release_after(B_F, 1, 4);
    @(negedge clk); push("reset_drop", 8'h00, -1); resetM = 1'b0;
    #1 chk("reset_mid_run", outv, 8'h00);
    repeat (2) @(negedge clk); resetM = 1'b1;
    repeat (4) @(negedge clk);
    press(B_H); push("enter_hora", ov(SH, 0, 0, 0), t0 + 3); release_after(B_H, 1, 4);
    press(B_H); push("exit_hora", 8'h00, t0 + 3); release_after(B_H, 1, 4);

    // cursor wrap
    press(B_F); push("cur_enter", ov(SF, 0, 0, 0), t0 + 3); release_after(B_F, 1, 4);
    press(B_D); push("der_1", ov(SF, 1, 0, 0), t0 + 3); release_after(B_D, 1, 4);
    press(B_D); push("der_2", ov(SF, 2, 0, 0), t0 + 3); release_after(B_D, 1, 4);
    press(B_D); push("der_wrap0", ov(SF, 0, 0, 0), t0 + 3); release_after(B_D, 1, 4);
    press(B_D); push("der_1b", ov(SF, 1, 0, 0), t0 + 3); release_after(B_D, 1, 4);
    press(B_I); push("izq_0", ov(SF, 0, 0, 0), t0 + 3); release_after(B_I, 1, 4);
    press(B_I); push("izq_wrap2", ov(SF, 2, 0, 0), t0 + 3); release_after(B_I, 1, 4);
    press(B_D | B_I); release_after(B_D | B_I, 1, 4);
    chk("both_dir_hold", outv, ov(SF, 2, 0, 0));
    press(B_F); push("cur_exit", 8'h00, t0 + 3); release_after(B_F, 1, 4);

    // strobes
    press(B_C); push("enter_crono", ov(SC, 0, 0, 0), t0 + 3); release_after(B_C, 1, 4);
    press(B_S); push("inc_rise", ov(SC, 0, 1, 0), t0 + 3);
    push("inc_fall", ov(SC, 0, 0, 0), t0 + 4); release_after(B_S, 50, 4);
    press(B_S | B_R); release_after(B_S | B_R, 1, 4);
    press(B_R); push("dec_rise", ov(SC, 0, 0, 1), t0 + 3);
    push("dec_fall", ov(SC, 0, 0, 0), t0 + 4); release_after(B_R, 1, 4);
    press(B_C); push("exit_crono", 8'h00, t0 + 3); release_after(B_C, 1, 4);

    // mode priority, direct switch, mode over edit, edits in REPOSO
    press(B_F | B_C); push("prio_fecha", ov(SF, 0, 0, 0), t0 + 3); release_after(B_F | B_C, 1, 4);
    press(B_D); push("prio_der", ov(SF, 1, 0, 0), t0 + 3); release_after(B_D, 1, 4);
    press(B_H); push("switch_hora", ov(SH, 0, 0, 0), t0 + 3); release_after(B_H, 1, 4);
    press(B_H); push("switch_exit", 8'h00, t0 + 3); release_after(B_H, 1, 4);
    press(B_S); release_after(B_S, 1, 6);
    press(B_F); push("moe_enter", ov(SF, 0, 0, 0), t0 + 3); release_after(B_F, 1, 4);
    press(B_H | B_S); push("mode_over_edit", ov(SH, 0, 0, 0), t0 + 3); release_after(B_H | B_S, 1, 4);
    press(B_H); push("moe_exit", 8'h00, t0 + 3); release_after(B_H, 1, 4);

    // inactivity timeout
    press(B_H); e = t0 + 3; push("to_enter", ov(SH, 0, 0, 0), e); release_after(B_H, 1, 0);
    while (cyc < e + 11) @(negedge clk);
    press(B_D); push("to_reload_der", ov(SH, 1, 0, 0), t0 + 3);
`ifdef EDIT_TIMEOUT_EN
    push("to_expire", 8'h00, t0 + 3 + 16); release_after(B_D, 1, 40);
`else
    release_after(B_D, 1, 60);
    chk("no_timeout", outv, ov(SH, 1, 0, 0));
    press(B_H); push("to_exit", 8'h00, t0 + 3); release_after(B_H, 1, 4);
`endif

    // reset mid-edit with buttons held through release
    press(B_F); push("rme_enter", ov(SF, 0, 0, 0), t0 + 3);
    repeat (4) @(negedge clk);
    press(B_S); push("rme_inc_rise", ov(SF, 0, 1, 0), t0 + 3);
    push("rme_inc_fall", ov(SF, 0, 0, 0), t0 + 4);
    repeat (6) @(negedge clk);
    @(negedge clk); push("rme_reset_drop", 8'h00, -1); resetM = 1'b0;
    #1 chk("rme_during_reset", outv, 8'h00);
    repeat (2) @(negedge clk); resetM = 1'b1;
    repeat (10) @(negedge clk);
    chk("rme_held_after_reset", outv, 8'h00);
    @(negedge clk); btn = '0;
    repeat (4) @(negedge clk);
    press(B_F); push("rme_reenter", ov(SF, 0, 0, 0), t0 + 3); release_after(B_F, 1, 4);
    press(B_S); push("rme_inc2_rise", ov(SF, 0, 1, 0), t0 + 3);
    push("rme_inc2_fall", ov(SF, 0, 0, 0), t0 + 4); release_after(B_S, 1, 4);
    press(B_F); push("rme_exit", 8'h00, t0 + 3); release_after(B_F, 1, 4);

    repeat (10) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: %0d expected changes never seen, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
